// File: rtl/bus_master_if.sv
// CPU-side bus master: turns single-cycle load/store requests into
// hello/ack bus transactions, stalling the pipeline until the slave answers
// or a bounded timeout expires.
module bus_master_if #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  output logic          cpu_err_o,
  output logic [DW-1:0] m_data_o,
  output logic [AW-1:0] m_addr_o,
  output logic          m_we_o,
  output logic          m_hello_o,
  input  logic [DW-1:0] m_data_i,
  input  logic          m_ack_i
);

  // TIMEOUT is at most 255, so an 8-bit counter always suffices.
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          hello_q, hello_d;
  logic          we_q,    we_d;
  logic          err_q,   err_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hello_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hello_q <= hello_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and next-value logic; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          addr_d  = cpu_addr_i;
          we_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // An ack always beats a coincident timeout.
        if (m_ack_i) begin
          if (!we_q) begin
            rdata_d = m_data_i;
          end
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    hello_d = (state_d == S_BUSY);
  end

  assign cpu_stall_o = ((state_q == S_IDLE) && cpu_req_i) || (state_q == S_BUSY);
  assign m_hello_o   = hello_q;
  assign m_we_o      = we_q;
  assign m_addr_o    = addr_q;
  assign m_data_o    = wdata_q;
  assign cpu_rdata_o = rdata_q;
  assign cpu_err_o   = err_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Randomized bench for bus_master_if against a transaction-level model.
module tb_bus_master_if;

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_stall_o;
  logic          cpu_err_o;
  logic [DW-1:0] m_data_o;
  logic [AW-1:0] m_addr_o;
  logic          m_we_o;
  logic          m_hello_o;
  logic [DW-1:0] m_data_i;
  logic          m_ack_i;

  int total = 0;
  int bad   = 0;

  // Reference state: what the CPU and bus should currently observe.
  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  logic [AW-1:0] exp_addr;
  logic          exp_we;
  logic [DW-1:0] exp_wd;

  bus_master_if #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .cpu_err_o   (cpu_err_o),
    .m_data_o    (m_data_o),
    .m_addr_o    (m_addr_o),
    .m_we_o      (m_we_o),
    .m_hello_o   (m_hello_o),
    .m_data_i    (m_data_i),
    .m_ack_i     (m_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered outputs that should simply hold the model values.
  task automatic check_held(input string tag);
    check_eq({tag, "_rdata"}, cpu_rdata_o, exp_rdata);
    check_eq({tag, "_err"},   cpu_err_o,   32'(exp_err));
    check_eq({tag, "_addr"},  m_addr_o,    exp_addr);
    check_eq({tag, "_we"},    m_we_o,      32'(exp_we));
    check_eq({tag, "_wdata"}, m_data_o,    exp_wd);
  endtask

  task automatic randomize_cpu();
    cpu_req_i   = 1'($urandom_range(0, 1));
    cpu_we_i    = 1'($urandom_range(0, 1));
    cpu_addr_i  = $urandom;
    cpu_wdata_i = $urandom;
  endtask

  // Idle cycles with no request; acks on the bus must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cpu_req_i   = 1'b0;
      cpu_we_i    = 1'($urandom_range(0, 1));
      cpu_addr_i  = $urandom;
      cpu_wdata_i = $urandom;
      m_ack_i     = 1'b1;
      m_data_i    = $urandom;
      #1;
      check_eq("idle_stall", cpu_stall_o, 0);
      check_eq("idle_hello", m_hello_o, 0);
      check_held("idle");
    end
  endtask

  // One transaction; ack arrives in BUSY cycle ack_at (never if > TIMEOUT).
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int ack_at, input logic [DW-1:0] ack_data);
    int hellos;
    logic acked;
    tick();
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    m_ack_i     = 1'b1;
    m_data_i    = $urandom;
    #1;
    check_eq("req_stall", cpu_stall_o, 1);
    check_eq("req_hello", m_hello_o, 0);
    exp_addr = addr;
    exp_we   = we;
    exp_wd   = wd;
    exp_err  = 1'b0;
    hellos   = 0;
    acked    = 1'b0;
    for (int b = 1; b <= int'(TIMEOUT); b++) begin
      tick();
      randomize_cpu();
      m_ack_i  = (b == ack_at);
      m_data_i = (b == ack_at) ? ack_data : $urandom;
      #1;
      if (m_hello_o) hellos++;
      check_eq("busy_hello", m_hello_o, 1);
      check_eq("busy_stall", cpu_stall_o, 1);
      check_eq("busy_addr",  m_addr_o, exp_addr);
      check_eq("busy_we",    m_we_o, 32'(exp_we));
      check_eq("busy_wdata", m_data_o, exp_wd);
      if (b == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    check_eq("hello_cycles", hellos, (ack_at <= int'(TIMEOUT)) ? ack_at : TIMEOUT);
    if (acked) begin
      if (!we) exp_rdata = ack_data;
      exp_err = 1'b0;
    end else begin
      exp_rdata = '0;
      exp_err   = 1'b1;
    end
    tick();
    randomize_cpu();
    m_ack_i  = 1'($urandom_range(0, 1));
    m_data_i = $urandom;
    #1;
    check_eq("done_hello", m_hello_o, 0);
    check_eq("done_stall", cpu_stall_o, 0);
    check_held("done");
  endtask

  initial begin
    rst         = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    m_data_i    = '0;
    m_ack_i     = 1'b0;
    exp_rdata   = '0;
    exp_err     = 1'b0;
    exp_addr    = '0;
    exp_we      = 1'b0;
    exp_wd      = '0;

    tick();
    tick();
    check_eq("rst_hello", m_hello_o, 0);
    check_eq("rst_stall", cpu_stall_o, 0);
    check_held("rst");
    rst = 1'b0;

    // Minimum-latency load.
    txn(1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF);
    idle(1);
    // Store with three wait states: rdata must hold.
    txn(1'b1, 32'h2004, 32'h12345678, 4, 32'hCAFEF00D);
    idle(2);
    // Timeout with no ack at all.
    txn(1'b0, 32'h40, 32'h0, TIMEOUT + 5, 32'h0);
    idle(1);
    // Ack on the very cycle the timeout would fire.
    txn(1'b0, 32'h44, 32'h0, TIMEOUT, 32'hA5A5A5A5);

    // Reset in the second BUSY cycle, late ack right after.
    tick();
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h80;
    m_ack_i    = 1'b0;
    #1;
    tick();
    cpu_req_i = 1'b0;
    #1;
    check_eq("rstmid_hello1", m_hello_o, 1);
    tick();
    rst = 1'b1;
    #1;
    check_eq("rstmid_hello2", m_hello_o, 1);
    tick();
    rst      = 1'b0;
    m_ack_i  = 1'b1;
    m_data_i = 32'h55AA55AA;
    #1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    exp_addr  = '0;
    exp_we    = 1'b0;
    exp_wd    = '0;
    check_eq("rstmid_hello3", m_hello_o, 0);
    check_eq("rstmid_stall", cpu_stall_o, 0);
    check_held("rstmid");
    idle(2);

    // Back-to-back loads with no gap.
    txn(1'b0, 32'h100, 32'h0, 1, 32'h11111111);
    txn(1'b0, 32'h104, 32'h0, 1, 32'h22222222);

    // Randomized traffic, including timeouts and back-to-back issue.
    for (int t = 0; t < 60; t++) begin
      txn(1'($urandom_range(0, 1)), $urandom, $urandom,
          int'($urandom_range(1, TIMEOUT + 2)), $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
